// File: rtl/traffic_pkg.sv
// Shared traffic-light encodings, side-road sensor FSM states and sizing helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } lamp_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_REQ   = 2'd2,
        S_SERVE = 2'd3
    } sensor_state_t;

    // Wide enough to hold MAX_WAIT-1 with one bit of headroom.
    function automatic int unsigned wait_timer_w(input int unsigned max_wait);
        return $clog2(max_wait) + 1;
    endfunction

endpackage

// File: rtl/loop_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter.
module loop_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear_n,
    input  logic raw_in,
    output logic level_out
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    // The DEBOUNCE_CYCLES-th consecutive mismatching cycle commits the new level.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt       <= '0;
            level_out <= 1'b0;
        end else if (sync_b == level_out) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt       <= '0;
            level_out <= sync_b;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/side_road_sensor.sv
// Turns the raw side-road loop into a sticky car request, cleared when EW goes green.
module side_road_sensor
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_W         = 4,
    parameter int unsigned CAR_THRESH      = 2,
    parameter int unsigned MAX_WAIT        = 64
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               loop_raw,
    input  logic [1:0]         ew_light,
    output logic               x,
    output logic [COUNT_W-1:0] car_count,
    output logic               starved
);

    localparam int unsigned TMR_W = wait_timer_w(MAX_WAIT);
    localparam int unsigned SUM_W = COUNT_W + 1;

    sensor_state_t      state;
    sensor_state_t      state_nxt;
    logic               loop_d;
    logic               loop_d_q;
    logic               arrive;
    logic [TMR_W-1:0]   wait_tmr;
    logic [TMR_W-1:0]   tmr_nxt;
    logic [COUNT_W-1:0] cnt_nxt;
    logic               x_nxt;
    logic               starved_nxt;
    logic               green;
    logic               thr_hit;
    logic               timeout;

    loop_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .clear_n  (clear_n),
        .raw_in   (loop_raw),
        .level_out(loop_d)
    );

    // Registered rising-edge detect on the accepted loop level.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            loop_d_q <= 1'b0;
            arrive   <= 1'b0;
        end else begin
            loop_d_q <= loop_d;
            arrive   <= loop_d & ~loop_d_q;
        end
    end

    // Lamp code 3 is not GREEN, so it never serves.
    assign green   = (ew_light == GREEN);
    assign thr_hit = (SUM_W'(car_count) + SUM_W'(arrive)) >= SUM_W'(CAR_THRESH);
    assign timeout = (wait_tmr == TMR_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (green) begin
            state_nxt = S_SERVE;
        end else begin
            unique case (state)
                S_IDLE:  if (arrive) state_nxt = thr_hit ? S_REQ : S_WAIT;
                S_WAIT:  if (thr_hit || timeout) state_nxt = S_REQ;
                S_REQ:   state_nxt = S_REQ;
                S_SERVE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Threshold is tested first so a coincident timeout does not flag starvation.
    always_comb begin
        cnt_nxt     = car_count;
        tmr_nxt     = wait_tmr;
        x_nxt       = x;
        starved_nxt = starved;
        if (state_nxt == S_SERVE) begin
            cnt_nxt     = '0;
            tmr_nxt     = '0;
            x_nxt       = 1'b0;
            starved_nxt = 1'b0;
        end else begin
            if (arrive && state != S_SERVE && car_count != '1) begin
                cnt_nxt = car_count + COUNT_W'(1);
            end
            x_nxt = (state_nxt == S_REQ);
            if (state_nxt == S_IDLE) begin
                tmr_nxt     = '0;
                starved_nxt = 1'b0;
            end else if (state == S_WAIT && !timeout) begin
                tmr_nxt = wait_tmr + TMR_W'(1);
            end
            if (state == S_WAIT && state_nxt == S_REQ && !thr_hit) begin
                starved_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            car_count <= '0;
            wait_tmr  <= '0;
            x         <= 1'b0;
            starved   <= 1'b0;
        end else begin
            car_count <= cnt_nxt;
            wait_tmr  <= tmr_nxt;
            x         <= x_nxt;
            starved   <= starved_nxt;
        end
    end

endmodule
